// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter.
//   arb_state_t : arbiter FSM states
//   arb_owner_t : which requester owns the current transaction
//   WSTRB_W     : byte-enable width (data path is fixed at 32 bits)
package mem_arb_pkg;

    localparam int WSTRB_W = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/arb_pick.sv
// Combinational owner picker for the memory port arbiter.
// Build option: MEM_ARB_ROUND_ROBIN_EN selects alternating priority under
// contention; without it data always beats fetch.
// Ports:
//   i_valid_i     fetch request valid
//   d_valid_i     data request valid
//   last_owner_i  owner served last (round-robin build only)
//   grant_valid_o at least one requester is valid
//   owner_o       selected requester
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic       i_valid_i,
    input  logic       d_valid_i,
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  arb_owner_t last_owner_i,
`endif
    output logic       grant_valid_o,
    output arb_owner_t owner_o
);

    always_comb begin
        grant_valid_o = i_valid_i | d_valid_i;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        // Under contention serve whoever was not served last; a sole
        // requester wins outright.
        if (i_valid_i && d_valid_i) begin
            owner_o = (last_owner_i == OWN_D) ? OWN_I : OWN_D;
        end else begin
            owner_o = d_valid_i ? OWN_D : OWN_I;
        end
`else
        owner_o = d_valid_i ? OWN_D : OWN_I;
`endif
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the instruction-fetch path and the
// load/store path. One memory transaction is outstanding at a time.
// Build option: MEM_ARB_ROUND_ROBIN_EN (alternate owners under contention,
// adds a last_owner register); default is fixed data-over-fetch priority.
// DATA_W must stay 32 because byte enables are WSTRB_W = 4 bits.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no transaction; ready pulses to the picked valid requester
// ISSUE    | mem_req_o held with latched fields until mem_gnt_i
// WAIT_RSP | request granted; waiting for mem_rvalid_i
//
// Ports:
//   clk_i, rstn_i                      clock, async active-low reset
//   i_req_valid_i/addr_i/ready_o       fetch request channel (read only)
//   i_rsp_valid_o/data_o               fetch response strobe and data
//   d_req_valid_i/addr_i/we_i/wdata_i/wstrb_i/ready_o  data request channel
//   d_rsp_valid_o/data_o               data response strobe and data
//   mem_req_o/addr_o/we_o/wdata_o/wstrb_o  memory request
//   mem_gnt_i, mem_rvalid_i, mem_rdata_i   memory grant and completion
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               i_req_valid_i,
    input  logic [ADDR_W-1:0]  i_req_addr_i,
    output logic               i_req_ready_o,
    output logic               i_rsp_valid_o,
    output logic [DATA_W-1:0]  i_rsp_data_o,
    input  logic               d_req_valid_i,
    input  logic [ADDR_W-1:0]  d_req_addr_i,
    input  logic               d_req_we_i,
    input  logic [DATA_W-1:0]  d_req_wdata_i,
    input  logic [WSTRB_W-1:0] d_req_wstrb_i,
    output logic               d_req_ready_o,
    output logic               d_rsp_valid_o,
    output logic [DATA_W-1:0]  d_rsp_data_o,
    output logic               mem_req_o,
    output logic [ADDR_W-1:0]  mem_addr_o,
    output logic               mem_we_o,
    output logic [DATA_W-1:0]  mem_wdata_o,
    output logic [WSTRB_W-1:0] mem_wstrb_o,
    input  logic               mem_gnt_i,
    input  logic               mem_rvalid_i,
    input  logic [DATA_W-1:0]  mem_rdata_i
);

    arb_state_t         state_q, state_d;
    arb_owner_t         owner_q, owner_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               we_q, we_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [WSTRB_W-1:0] wstrb_q, wstrb_d;
    logic               i_rsp_valid_q, i_rsp_valid_d;
    logic [DATA_W-1:0]  i_rsp_data_q, i_rsp_data_d;
    logic               d_rsp_valid_q, d_rsp_valid_d;
    logic [DATA_W-1:0]  d_rsp_data_q, d_rsp_data_d;

    logic               pick_valid;
    arb_owner_t         pick_owner;
    logic               accept;
    logic               rsp_done;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    arb_owner_t         last_owner_q, last_owner_d;
`endif

    arb_pick u_pick (
        .i_valid_i     (i_req_valid_i),
        .d_valid_i     (d_req_valid_i),
`ifdef MEM_ARB_ROUND_ROBIN_EN
        .last_owner_i  (last_owner_q),
`endif
        .grant_valid_o (pick_valid),
        .owner_o       (pick_owner)
    );

    assign accept   = (state_q == IDLE) && pick_valid;
    assign rsp_done = (state_q == WAIT_RSP) && mem_rvalid_i;

    // State register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; gnt outside ISSUE and rvalid outside WAIT_RSP fall
    // through to the hold default.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (pick_valid)   state_d = ISSUE;
            ISSUE:    if (mem_gnt_i)    state_d = WAIT_RSP;
            WAIT_RSP: if (mem_rvalid_i) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // Outputs; memory fields are zeroed outside ISSUE so the bus is quiet
    // whenever no request is presented.
    always_comb begin
        i_req_ready_o = accept && (pick_owner == OWN_I);
        d_req_ready_o = accept && (pick_owner == OWN_D);
        mem_req_o     = (state_q == ISSUE);
        mem_addr_o    = mem_req_o ? addr_q  : '0;
        mem_we_o      = mem_req_o ? we_q    : 1'b0;
        mem_wdata_o   = mem_req_o ? wdata_q : '0;
        mem_wstrb_o   = mem_req_o ? wstrb_q : '0;
        i_rsp_valid_o = i_rsp_valid_q;
        i_rsp_data_o  = i_rsp_data_q;
        d_rsp_valid_o = d_rsp_valid_q;
        d_rsp_data_o  = d_rsp_data_q;
    end

    // Request latch and response capture
    always_comb begin
        owner_d = owner_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        if (accept) begin
            owner_d = pick_owner;
            if (pick_owner == OWN_D) begin
                addr_d  = d_req_addr_i;
                we_d    = d_req_we_i;
                wdata_d = d_req_wdata_i;
                wstrb_d = d_req_we_i ? d_req_wstrb_i : '0;
            end else begin
                addr_d  = i_req_addr_i;
                we_d    = 1'b0;
                wdata_d = '0;
                wstrb_d = '0;
            end
        end

        i_rsp_valid_d = rsp_done && (owner_q == OWN_I);
        d_rsp_valid_d = rsp_done && (owner_q == OWN_D);
        i_rsp_data_d  = i_rsp_valid_d ? mem_rdata_i : i_rsp_data_q;
        d_rsp_data_d  = d_rsp_valid_d ? mem_rdata_i : d_rsp_data_q;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            owner_q       <= OWN_I;
            addr_q        <= '0;
            we_q          <= 1'b0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            i_rsp_valid_q <= 1'b0;
            i_rsp_data_q  <= '0;
            d_rsp_valid_q <= 1'b0;
            d_rsp_data_q  <= '0;
        end else begin
            owner_q       <= owner_d;
            addr_q        <= addr_d;
            we_q          <= we_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            i_rsp_valid_q <= i_rsp_valid_d;
            i_rsp_data_q  <= i_rsp_data_d;
            d_rsp_valid_q <= d_rsp_valid_d;
            d_rsp_data_q  <= d_rsp_data_d;
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_comb begin
        last_owner_d = accept ? pick_owner : last_owner_q;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            last_owner_q <= OWN_D;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port memory between the CPU instruction-fetch path and the load/store path. Each requester sees a valid/ready request channel and a one-cycle response strobe. On the memory side the block issues req/gnt/rvalid transactions, with one transaction outstanding at a time. The block sits between the cpu core and the unified code/data memory, replacing direct ROM addressing.

Parameters:
ADDR_W, 32, byte address width of both requesters and memory
DATA_W, 32, data width; must be 32 (wstrb is 4 bits)

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
i_req_valid_i  in  1  fetch request valid
i_req_addr_i  in  ADDR_W  fetch address (read only)
i_req_ready_o  out  1  fetch request accepted this cycle
i_rsp_valid_o  out  1  fetch response strobe
i_rsp_data_o  out  DATA_W  fetch read data
d_req_valid_i  in  1  data request valid
d_req_addr_i  in  ADDR_W  data address
d_req_we_i  in  1  1 = write, 0 = read
d_req_wdata_i  in  DATA_W  write data
d_req_wstrb_i  in  4  byte enables for writes
d_req_ready_o  out  1  data request accepted this cycle
d_rsp_valid_o  out  1  data response strobe (reads and writes)
d_rsp_data_o  out  DATA_W  data read data
mem_req_o  out  1  memory request
mem_addr_o  out  ADDR_W  memory address
mem_we_o  out  1  memory write enable
mem_wdata_o  out  DATA_W  memory write data
mem_wstrb_o  out  4  memory byte enables (0 for reads)
mem_gnt_i  in  1  memory accepted request
mem_rvalid_i  in  1  memory completion, one per granted request
mem_rdata_i  in  DATA_W  memory read data

Behaviour:
- Reset (rstn_i low, asynchronous): state is IDLE, every output is 0, latched request regs are 0, and any in-flight transaction is dropped. Memory shares rstn_i.
- State machine ARB_STATE:
  - IDLE: if any valid, the picker selects an owner. The block pulses owner's *_req_ready_o for 1 cycle (combinational from valid, IDLE only), latches addr/we/wdata/wstrb, and goes to ISSUE. With no valid, it stays in IDLE.
  - ISSUE: mem_req_o = 1 with the latched fields, held stable until mem_gnt_i. On gnt it goes to WAIT_RSP.
  - WAIT_RSP: mem_req_o = 0. On mem_rvalid_i, the owner's *_rsp_valid_o = 1 for that cycle and *_rsp_data_o = mem_rdata_i (registered, so visible the cycle after rvalid together with the strobe). The block then returns to IDLE.
- Fetch transactions always have we = 0 and wstrb = 0. For data reads, wstrb is forced to 0 regardless of input.
- Timing: accept at cycle N, mem_req at N+1. With gnt at N+1 and rvalid at N+2, rsp_valid is at N+3. Minimum occupancy is 3 cycles per transaction.
- Fixed priority (default): data beats fetch when both are valid in IDLE.
- Protocol rules:
  - mem_gnt_i outside ISSUE and mem_rvalid_i outside WAIT_RSP are ignored.
  - rvalid in the same cycle as gnt is illegal; the memory guarantees rvalid at or after gnt+1.
- A requester deasserting valid before ready is permitted; nothing is latched.
- The non-selected requester is never given ready while a transaction is outstanding.
- rsp_data_o holds its last value between strobes. The non-owner's rsp_data_o is unchanged.

Optional Feature:
MEM_ARB_ROUND_ROBIN_EN. When defined, a 1-bit last_owner register (reset = OWN_D) selects the requester not served last under contention. A sole requester always wins and updates last_owner. When not defined, fixed data-over-fetch priority applies and no last_owner register exists.

Decomposition:
- Package mem_arb_pkg:
  - typedef enum ARB_STATE {IDLE, ISSUE, WAIT_RSP}.
  - typedef enum ARB_OWNER {OWN_I, OWN_D}.
  - localparam WSTRB_W = 4.
- One sub-module, arb_pick: a combinational picker taking the two valids (and last_owner when MEM_ARB_ROUND_ROBIN_EN is defined). It outputs grant_valid and the selected owner.

Test Plan:
1. Fetch-only at addr 0x10. gnt same cycle as req, rvalid 1 cycle later with 0xDEADBEEF. Required: i_req_ready_o at N, mem_addr_o = 0x10 at N+1, i_rsp_valid_o = 1 with 0xDEADBEEF at N+3, d_rsp_valid_o stays 0.
2. Both valid in the same cycle (fetch 0x0, data read 0x100), fixed priority. Required: data is served first (mem_addr_o = 0x100), then fetch 0x0. Each response goes to its own port.
3. gnt withheld for 3 cycles. Required: mem_req_o = 1 with addr/we/wdata/wstrb stable for 4 cycles, and no ready to either requester.
4. Data write to 0x1000, wdata 0x41, wstrb 4'b0001. Required: mem_we_o = 1, mem_wstrb_o = 0001, and d_rsp_valid_o pulses once after rvalid.
5. rstn_i low during WAIT_RSP. Required: all outputs 0 immediately, and a late rvalid after release is ignored. A new fetch then completes normally.
6. MEM_ARB_ROUND_ROBIN_EN defined, both valid continuously for 4 transactions. Required: owners alternate I, D, I, D.
